// File: rtl/lms_pkg.sv
// Shared widths, FSM state encoding and index-width helper for the LMS update sequencer.
package lms_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned PROD_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      ISSUE  = 3'd2,
      WAIT   = 3'd3,
      UPDATE = 3'd4,
      DONE   = 3'd5
   } state_e;

   // Tap index width; a single-tap bank still gets one index bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lms_weight_sat_add.sv
// Combinational weight update: w + (prod >>> MU_SHIFT), saturated or wrapped to 8 bits.
module lms_weight_sat_add
   import lms_pkg::*;
#(
   parameter int unsigned MU_SHIFT = 7,
   parameter bit          SAT_EN   = 1'b1
) (
   input  logic [DATA_W-1:0] w_i,
   input  logic [PROD_W-1:0] prod_i,
   output logic [DATA_W-1:0] w_o
);

   localparam logic signed [PROD_W:0] W_MAX = (PROD_W+1)'(127);
   localparam logic signed [PROD_W:0] W_MIN = (PROD_W+1)'(-128);

   logic signed [PROD_W-1:0] delta;
   logic signed [PROD_W:0]   sum;

   // Arithmetic shift floors toward -inf; sum is wide enough that it never overflows.
   always_comb begin
      delta = $signed(prod_i) >>> MU_SHIFT;
      sum   = {{(PROD_W+1-DATA_W){w_i[DATA_W-1]}}, w_i} + {delta[PROD_W-1], delta};
      if (!SAT_EN) begin
         w_o = sum[DATA_W-1:0];
      end else if (sum > W_MAX) begin
         w_o = 8'h7F;
      end else if (sum < W_MIN) begin
         w_o = 8'h80;
      end else begin
         w_o = sum[DATA_W-1:0];
      end
   end

endmodule

// File: rtl/lms_update_sequencer.sv
// Walks all taps through one shared multiplier and applies the LMS weight update.
module lms_update_sequencer
   import lms_pkg::*;
#(
   parameter int unsigned N_TAPS      = 4,
   parameter int unsigned MU_SHIFT    = 7,
   parameter int unsigned MUL_TIMEOUT = 15,
   parameter bit          SAT_EN      = 1'b1,
   localparam int unsigned IDX_W      = idx_w(N_TAPS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] e,
   output logic [IDX_W-1:0]  x_idx,
   input  logic [DATA_W-1:0] x_rd_data,
   output logic [DATA_W-1:0] mul_a,
   output logic [DATA_W-1:0] mul_b,
   output logic              mul_enable,
   input  logic              mul_done,
   input  logic [PROD_W-1:0] mul_q,
   input  logic [IDX_W-1:0]  w_rd_idx,
   output logic [DATA_W-1:0] w_rd_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned CNT_W = $clog2(MUL_TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    k_q, k_d;
   logic [DATA_W-1:0]   e_q, e_d;
   logic [DATA_W-1:0]   mul_a_q, mul_a_d;
   logic [DATA_W-1:0]   mul_b_q, mul_b_d;
   logic                mul_en_q, mul_en_d;
   logic [PROD_W-1:0]   prod_q, prod_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   w_q [N_TAPS];
   logic                w_we;
   logic [DATA_W-1:0]   w_new;

   lms_weight_sat_add #(
      .MU_SHIFT (MU_SHIFT),
      .SAT_EN   (SAT_EN)
   ) u_sat_add (
      .w_i    (w_q[k_q]),
      .prod_i (prod_q),
      .w_o    (w_new)
   );

   // Next-state and next-output logic; status outputs are registered from the next state.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      e_d      = e_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      w_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               e_d     = e;
               k_d     = '0;
               err_d   = 1'b0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            mul_b_d = x_rd_data;
            mul_a_d = e_q;
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (mul_done) begin
               prod_d  = mul_q;
               state_d = UPDATE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == CNT_W'(MUL_TIMEOUT)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         UPDATE: begin
            w_we = 1'b1;
            if (k_q == IDX_W'(N_TAPS - 1)) begin
               state_d = DONE;
            end else begin
               k_d     = k_q + IDX_W'(1);
               state_d = FETCH;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      mul_en_d = (state_d == ISSUE);
      done_d   = (state_d == DONE);
      busy_d   = (state_d != IDLE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         k_q      <= '0;
         e_q      <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         mul_en_q <= 1'b0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < int'(N_TAPS); i++) begin
            w_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         e_q      <= e_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         mul_en_q <= mul_en_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         if (w_we) begin
            w_q[k_q] <= w_new;
         end
      end
   end

   // Weight read port sees the registered bank, so a same-cycle write shows the old value.
   assign w_rd_data  = (32'(w_rd_idx) < N_TAPS) ? w_q[w_rd_idx] : '0;
   assign x_idx      = k_q;
   assign mul_a      = mul_a_q;
   assign mul_b      = mul_b_q;
   assign mul_enable = mul_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_lms_update_sequencer.sv
// Directed self-checking bench for lms_update_sequencer with a behavioural multiplier.
module tb_lms_update_sequencer;

   localparam int unsigned LAT = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  e;
   logic [1:0]  x_idx, x_idx_w;
   logic [7:0]  x_rd_data, x_rd_data_w;
   logic [7:0]  mul_a, mul_b, mul_a_w, mul_b_w;
   logic        mul_enable, mul_enable_w;
   logic        mul_done;
   logic [15:0] mul_q;
   logic [1:0]  w_rd_idx;
   logic [7:0]  w_rd_data, w_rd_data_w;
   logic        busy, done, err, busy_w, done_w, err_w;

   logic [7:0]  x_mem [4];
   int          errors = 0;
   int          checks = 0;
   int          en_cnt = 0;
   int          rem = 0;
   bit          hang = 1'b0;
   logic [15:0] mq;
   int          n;
   logic [7:0]  rv, rvw;

   lms_update_sequencer #(.N_TAPS(4), .MU_SHIFT(7), .MUL_TIMEOUT(15), .SAT_EN(1'b1)) u_dut (
      .clock(clock), .reset(reset), .start(start), .e(e),
      .x_idx(x_idx), .x_rd_data(x_rd_data),
      .mul_a(mul_a), .mul_b(mul_b), .mul_enable(mul_enable),
      .mul_done(mul_done), .mul_q(mul_q),
      .w_rd_idx(w_rd_idx), .w_rd_data(w_rd_data),
      .busy(busy), .done(done), .err(err)
   );

   lms_update_sequencer #(.N_TAPS(4), .MU_SHIFT(7), .MUL_TIMEOUT(15), .SAT_EN(1'b0)) u_wrap (
      .clock(clock), .reset(reset), .start(start), .e(e),
      .x_idx(x_idx_w), .x_rd_data(x_rd_data_w),
      .mul_a(mul_a_w), .mul_b(mul_b_w), .mul_enable(mul_enable_w),
      .mul_done(mul_done), .mul_q(mul_q),
      .w_rd_idx(w_rd_idx), .w_rd_data(w_rd_data_w),
      .busy(busy_w), .done(done_w), .err(err_w)
   );

   always #5 clock = ~clock;

   assign x_rd_data   = x_mem[x_idx];
   assign x_rd_data_w = x_mem[x_idx_w];

   // Multiplier model: done in the LAT-th WAIT cycle, unless hang is set.
   always @(negedge clock) begin
      logic signed [15:0] pa, pb;
      mul_done = 1'b0;
      if (mul_enable) begin
         en_cnt++;
         pa  = {{8{mul_a[7]}}, mul_a};
         pb  = {{8{mul_b[7]}}, mul_b};
         mq  = pa * pb;
         rem = LAT;
      end else if (rem > 0) begin
         rem--;
         if (rem == 0 && !hang) begin
            mul_done = 1'b1;
            mul_q    = mq;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic start_pass(input logic [7:0] ev);
      @(negedge clock);
      e     = ev;
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // Counts negedges after the accept edge until done; 0 means the bound expired.
   task automatic wait_done(input int stray_n, output int cyc);
      cyc = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clock);
         start = (i == stray_n);
         if (done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic rd(input int idx, output logic [7:0] v, output logic [7:0] vw);
      w_rd_idx = 2'(idx);
      #1;
      v  = w_rd_data;
      vw = w_rd_data_w;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; e = '0; w_rd_idx = '0; mul_q = '0; mul_done = 1'b0;
      for (int i = 0; i < 4; i++) x_mem[i] = 8'h00;
      repeat (3) @(negedge clock);
      reset = 1'b1;

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_mul_en", mul_enable, 0);
      check("rst_x_idx", x_idx, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);

      // Reset mid-pass clears weights and aborts the pass
      x_mem[0] = 8'h40; x_mem[1] = 8'hC0; x_mem[2] = 8'h10; x_mem[3] = 8'h00;
      start_pass(8'h40);
      repeat (8) @(negedge clock);
      rd(0, rv, rvw);
      check("mid_w0", rv, 8'h20);
      check("mid_busy", busy, 1);
      do_reset();
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      check("mrst_err", err, 0);
      check("mrst_mul_en", mul_enable, 0);
      for (int i = 0; i < 4; i++) begin
         rd(i, rv, rvw);
         check($sformatf("mrst_w%0d", i), rv, 8'h00);
      end
      repeat (25) @(negedge clock);
      check("mrst_stays_idle", busy, 0);

      // Normal pass, L=2
      en_cnt = 0;
      start_pass(8'h40);
      wait_done(0, n);
      check("norm_done_cyc", n, 21);
      check("norm_busy_in_done", busy, 1);
      check("norm_en_cnt", en_cnt, 4);
      @(negedge clock);
      check("norm_done_pulse", done, 0);
      check("norm_busy_after", busy, 0);
      rd(0, rv, rvw); check("norm_w0", rv, 8'h20);
      rd(1, rv, rvw); check("norm_w1", rv, 8'hE0);
      rd(2, rv, rvw); check("norm_w2", rv, 8'h08);
      rd(3, rv, rvw); check("norm_w3", rv, 8'h00);

      // start while busy and in DONE is ignored
      do_reset();
      en_cnt = 0;
      start_pass(8'h40);
      wait_done(5, n);
      check("ign_done_cyc", n, 21);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("ign_busy_after_done", busy, 0);
      check("ign_en_cnt", en_cnt, 4);
      rd(0, rv, rvw); check("ign_w0", rv, 8'h20);
      rd(1, rv, rvw); check("ign_w1", rv, 8'hE0);
      rd(2, rv, rvw); check("ign_w2", rv, 8'h08);
      repeat (4) @(negedge clock);
      check("ign_still_idle", busy, 0);

      // Saturation vs wrap
      do_reset();
      x_mem[0] = 8'h7F; x_mem[1] = 8'h00; x_mem[2] = 8'h00; x_mem[3] = 8'h00;
      start_pass(8'h7F);
      wait_done(0, n);
      check("sat1_done_cyc", n, 21);
      rd(0, rv, rvw);
      check("sat1_w0_sat", rv, 8'h7E);
      check("sat1_w0_wrap", rvw, 8'h7E);
      start_pass(8'h7F);
      wait_done(0, n);
      rd(0, rv, rvw);
      check("sat2_w0_sat", rv, 8'h7F);
      check("sat2_w0_wrap", rvw, 8'hFC);

      // Floor rounding of -1 >>> 7
      do_reset();
      x_mem[0] = 8'h01;
      start_pass(8'hFF);
      wait_done(0, n);
      rd(0, rv, rvw); check("floor_w0", rv, 8'hFF);
      rd(1, rv, rvw); check("floor_w1", rv, 8'h00);

      // Timeout
      hang = 1'b1;
      en_cnt = 0;
      start_pass(8'hFF);
      wait_done(0, n);
      check("to_done_cyc", n, 18);
      check("to_err", err, 1);
      check("to_en_cnt", en_cnt, 1);
      @(negedge clock);
      check("to_err_sticky", err, 1);
      check("to_busy_after", busy, 0);
      rd(0, rv, rvw); check("to_w0_kept", rv, 8'hFF);
      rd(1, rv, rvw); check("to_w1_kept", rv, 8'h00);
      hang = 1'b0;
      start_pass(8'hFF);
      @(negedge clock);
      check("to_err_cleared", err, 0);
      check("to_restart_busy", busy, 1);
      wait_done(0, n);
      check("to_restart_done_cyc", n, 20);
      check("to_restart_err", err, 0);
      rd(0, rv, rvw); check("to_restart_w0", rv, 8'hFE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
